// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result handshake bundle for muldiv_unit
interface muldiv_unit_if;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_funct3;
  logic        i_word;
  logic [63:0] i_rs1_value;
  logic [63:0] i_rs2_value;
  logic [4:0]  i_rd;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_result;
  logic [4:0]  o_rd;
  modport slave (
    input  i_valid, i_funct3, i_word, i_rs1_value, i_rs2_value, i_rd, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_rd
  );
  modport master (
    output i_valid, i_funct3, i_word, i_rs1_value, i_rs2_value, i_rd, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_rd
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M mul/div; MULDIV_FAST_EN sends div-by-zero, overflow and zero multiplies straight to DONE
module muldiv_unit #(
  parameter int BITS_PER_CYCLE = 1
) (
  input logic          i_clk,
  input logic          i_reset,
  muldiv_unit_if.slave bus
);
  localparam int ITER = 64 / BITS_PER_CYCLE;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [127:0] acc, acc_n, prod;
  logic [63:0] m, a_ext, b_ext, a_mag, b_mag, fast_res, sel, sh;
  logic [64:0] t;
  logic [6:0] cnt;
  logic [2:0] f3;
  logic w, a_neg, q_neg;
  logic is_div_i, a_sgn, b_sgn, w_i, a_neg_i, b_neg_i, accept, fast;
  function automatic logic [63:0] wfix(input logic wf, input logic [63:0] v);
    return wf ? {{32{v[31]}}, v[31:0]} : v;
  endfunction
  assign is_div_i = bus.i_funct3[2];
  assign a_sgn = is_div_i ? !bus.i_funct3[0] : bus.i_funct3[1:0] != 2'b11;
  assign b_sgn = is_div_i ? !bus.i_funct3[0] : !bus.i_funct3[1];
  assign w_i = bus.i_word && (is_div_i || bus.i_funct3[1:0] == 2'b00);
  assign a_ext = w_i ? {{32{a_sgn & bus.i_rs1_value[31]}}, bus.i_rs1_value[31:0]} : bus.i_rs1_value;
  assign b_ext = w_i ? {{32{b_sgn & bus.i_rs2_value[31]}}, bus.i_rs2_value[31:0]} : bus.i_rs2_value;
  assign a_neg_i = a_sgn & a_ext[63];
  assign b_neg_i = b_sgn & b_ext[63];
  assign a_mag = a_neg_i ? -a_ext : a_ext;
  assign b_mag = b_neg_i ? -b_ext : b_ext;
  assign accept = state == IDLE && bus.i_valid && !bus.i_flush;
  assign fast_res = !is_div_i ? 64'd0 : bus.i_funct3[1] ? (~|b_ext ? wfix(w_i, a_ext) : 64'd0) : (~|b_ext ? '1 : a_ext);
`ifdef MULDIV_FAST_EN
  assign fast = is_div_i ? (~|b_ext || (!bus.i_funct3[0] && &b_ext &&
                a_ext == (w_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))) : (~|a_ext || ~|b_ext);
`else
  assign fast = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = bus.i_flush ? IDLE :
              state == IDLE ? (bus.i_valid ? (fast ? DONE : CALC) : IDLE) :
              state == CALC ? (cnt == 7'(ITER - 1) ? FIX : CALC) :
              state == FIX  ? DONE :
              bus.i_ready   ? IDLE : DONE;
    bus.o_ready = state == IDLE;
    bus.o_valid = state == DONE;
  end
  // Multiply shifts the product right through acc; divide shifts the dividend left into the remainder half.
  always_comb begin
    acc_n = acc;
    t = '0;
    sh = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      t = {1'b0, acc_n[127:64]} + (acc_n[0] ? {1'b0, m} : 65'd0);
      sh = acc_n[126:63] - m;
      acc_n = f3[2] ? (acc_n[127:63] >= {1'b0, m} ? {sh, acc_n[62:0], 1'b1} : {acc_n[126:0], 1'b0}) : {t, acc_n[63:1]};
    end
  end
  always_comb begin
    prod = q_neg ? -acc : acc;
    sel = !f3[2] ? (f3[1:0] == 2'b00 ? prod[63:0] : prod[127:64]) :
          f3[1]  ? (a_neg ? -acc[127:64] : acc[127:64]) :
                   (q_neg ? -acc[63:0] : acc[63:0]);
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      acc <= '0;
      m <= '0;
      cnt <= '0;
      f3 <= '0;
      w <= 1'b0;
      a_neg <= 1'b0;
      q_neg <= 1'b0;
      bus.o_result <= '0;
      bus.o_rd <= '0;
    end else begin
      if (accept) begin
        acc <= {64'd0, is_div_i ? a_mag : b_mag};
        m <= is_div_i ? b_mag : a_mag;
        cnt <= '0;
        f3 <= bus.i_funct3;
        w <= w_i;
        a_neg <= a_neg_i;
        q_neg <= (a_neg_i ^ b_neg_i) & |b_ext;
        bus.o_rd <= bus.i_rd;
        if (fast) bus.o_result <= fast_res;
      end
      if (state == CALC) begin
        acc <= acc_n;
        cnt <= cnt + 7'd1;
      end
      if (state == FIX) bus.o_result <= wfix(w, sel);
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  localparam int BPC = 1;
  localparam int L = 64 / BPC + 2;
`ifdef MULDIV_FAST_EN
  localparam int FAST_L = 1;
`else
  localparam int FAST_L = L;
`endif
  typedef struct packed {
    logic [2:0]  f;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  muldiv_unit_if bus();
  muldiv_unit #(.BITS_PER_CYCLE(BPC)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic signed [129:0] xt(input logic sgn, input logic w, input logic [63:0] v);
    if (w) return sgn ? 130'($signed(v[31:0])) : 130'(v[31:0]);
    return sgn ? 130'($signed(v)) : 130'(v);
  endfunction

  // Reference: exact wide-integer arithmetic plus the architectural special-case rules.
  function automatic logic [63:0] model(input logic [2:0] f, input logic wd, input logic [63:0] a,
                                        input logic [63:0] b, output logic sp);
    logic w, sa, sb;
    logic signed [129:0] x, y, p, minv;
    logic [63:0] r;
    w = wd && (f == 3'b000 || f[2]);
    case (f)
      3'b000, 3'b001, 3'b100, 3'b110: begin sa = 1'b1; sb = 1'b1; end
      3'b010: begin sa = 1'b1; sb = 1'b0; end
      default: begin sa = 1'b0; sb = 1'b0; end
    endcase
    x = xt(sa, w, a);
    y = xt(sb, w, b);
    minv = w ? -(130'sd1 <<< 31) : -(130'sd1 <<< 63);
    if (!f[2]) begin
      p = x * y;
      r = f == 3'b000 ? p[63:0] : p[127:64];
      sp = x == 0 || y == 0;
    end else begin
      sp = y == 0 || (sa && y == -1 && x == minv);
      if (y == 0) r = f[1] ? x[63:0] : '1;
      else r = f[1] ? 64'(x % y) : 64'(x / y);
    end
    return w ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return {32'd0, 16'd0, 16'($urandom)};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic issue(input logic [2:0] f, input logic wd, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_funct3 = f;
    bus.i_word = wd;
    bus.i_rs1_value = a;
    bus.i_rs2_value = b;
    bus.i_rd = rd;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_funct3 = 3'($urandom);
    bus.i_rs1_value = {$urandom, $urandom};
    bus.i_rs2_value = {$urandom, $urandom};
    bus.i_rd = 5'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.o_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.o_ready); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.o_valid); end
    checks++; if (bus.o_result !== 64'd0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.o_result); end
    checks++; if (bus.o_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", bus.o_rd); end
  endtask

  task automatic test_directed();
    vec_t v[$];
    logic sp;
    logic [63:0] unused;
    int lat;
    v.push_back('{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB});
    v.push_back('{3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE});
    v.push_back('{3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD});
    v.push_back('{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE});
    v.push_back('{3'b101, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{3'b111, 1'b0, 64'd100, 64'd0, 64'd100});
    v.push_back('{3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000});
    v.push_back('{3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
    v.push_back('{3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000});
    foreach (v[i]) begin
      unused = model(v[i].f, v[i].w, v[i].a, v[i].b, sp);
      issue(v[i].f, v[i].w, v[i].a, v[i].b, 5'(5 + i));
      wait_valid(lat);
      checks++; if (bus.o_result !== v[i].e) begin errors++; $display("FAIL dir_result %0d got %h exp %h", i, bus.o_result, v[i].e); end
      checks++; if (bus.o_rd !== 5'(5 + i)) begin errors++; $display("FAIL dir_rd %0d got %0d exp %0d", i, bus.o_rd, 5 + i); end
      checks++; if (lat !== (sp ? FAST_L : L)) begin errors++; $display("FAIL dir_latency %0d got %0d exp %0d", i, lat, sp ? FAST_L : L); end
      take();
    end
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic wd, sp;
    logic [63:0] a, b, e;
    logic [4:0] rd;
    int lat;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      wd = 1'($urandom_range(0, 1));
      a = rnd64();
      b = rnd64();
      rd = 5'($urandom);
      e = model(f, wd, a, b, sp);
      issue(f, wd, a, b, rd);
      wait_valid(lat);
      checks++; if (bus.o_result !== e) begin errors++; $display("FAIL rand_result %0d f=%0d w=%0d a=%h b=%h got %h exp %h", i, f, wd, a, b, bus.o_result, e); end
      checks++; if (bus.o_rd !== rd) begin errors++; $display("FAIL rand_rd %0d got %0d exp %0d", i, bus.o_rd, rd); end
      checks++; if (lat !== (sp ? FAST_L : L)) begin errors++; $display("FAIL rand_latency %0d got %0d exp %0d", i, lat, sp ? FAST_L : L); end
      take();
    end
  endtask

  task automatic test_hold();
    int lat;
    issue(3'b101, 1'b0, 64'd1000, 64'd7, 5'd17);
    wait_valid(lat);
    checks++; if (lat !== L) begin errors++; $display("FAIL hold_latency got %0d exp %0d", lat, L); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL hold_valid %0d got %b exp 1", c, bus.o_valid); end
      checks++; if (bus.o_result !== 64'd142) begin errors++; $display("FAIL hold_result %0d got %h exp %h", c, bus.o_result, 64'd142); end
      checks++; if (bus.o_rd !== 5'd17) begin errors++; $display("FAIL hold_rd %0d got %0d exp 17", c, bus.o_rd); end
      checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL hold_ready %0d got %b exp 0", c, bus.o_ready); end
    end
    take();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %b exp 0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b exp 1", bus.o_ready); end
  endtask

  task automatic test_flush();
    logic seen;
    int lat;
    issue(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'd3);
    repeat (29) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL flush_calc_ready got %b exp 1", bus.o_ready); end
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      seen |= bus.o_valid;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_calc_no_valid got %b exp 0", seen); end
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_funct3 = 3'b000;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_no_accept got %b exp 1", bus.o_ready); end
    issue(3'b000, 1'b0, 64'd5, 64'd9, 5'd11);
    wait_valid(lat);
    checks++; if (bus.o_result !== 64'd45) begin errors++; $display("FAIL flush_done_result got %h exp %h", bus.o_result, 64'd45); end
    bus.i_ready = 1'b1;
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_flush = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL flush_done_valid got %b exp 0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL flush_done_ready got %b exp 1", bus.o_ready); end
  endtask

  task automatic test_reset_async();
    logic seen;
    int lat;
    issue(3'b000, 1'b0, 64'd3, 64'd5, 5'd9);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", bus.o_ready); end
    checks++; if (bus.o_result !== 64'd0) begin errors++; $display("FAIL arst_result got %h exp 0", bus.o_result); end
    checks++; if (bus.o_rd !== 5'd0) begin errors++; $display("FAIL arst_rd got %0d exp 0", bus.o_rd); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      seen |= bus.o_valid;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL arst_stale_valid got %b exp 0", seen); end
    issue(3'b000, 1'b0, 64'd6, 64'd7, 5'd1);
    wait_valid(lat);
    checks++; if (bus.o_result !== 64'd42) begin errors++; $display("FAIL arst_after_result got %h exp %h", bus.o_result, 64'd42); end
    checks++; if (lat !== L) begin errors++; $display("FAIL arst_after_latency got %0d exp %0d", lat, L); end
    take();
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_funct3 = 3'b000;
    bus.i_word = 1'b0;
    bus.i_rs1_value = '0;
    bus.i_rs2_value = '0;
    bus.i_rd = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_flush();
    test_reset_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
